traffic_light_monitor: RTL
==========================

# traffic_light_monitor

Passive checker on the four lamp buses driven by `traffic_light_controller`, sitting at the receiving end of that interface (beside the signal-head drivers, and in benches). Samples the buses every clock, decodes the current phase, and tracks the 8-phase rotation and per-phase dwell time. Raises sticky error flags on illegal lamp patterns, out-of-order phases and wrong dwell lengths, and counts completed rotations.

## Interface
- `GREEN_CYCLES`, default 20: required clocks per green phase.
- `YELLOW_CYCLES`, default 5: required clocks per yellow phase.
- `DUR_W`, default 8: dwell-counter width. Must satisfy 2^DUR_W-1 > max(GREEN_CYCLES, YELLOW_CYCLES).
- `CNT_W`, default 16: rotation-counter width.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `north_light`, `west_light`, `south_light`, `east_light` in 3 each: lamp buses. Bit2 is red, bit1 is yellow, bit0 is green.
- `clear` in 1: synchronous clear of the three error flags.
- `phase` out 3: decoded phase. 0 NG, 1 NY, 2 WG, 3 WY, 4 SG, 5 SY, 6 EG, 7 EY.
- `phase_valid` out 1: high when `phase` is locked and legal.
- `err_pattern` out 1: sticky flag for an illegal lamp pattern.
- `err_order` out 1: sticky flag for a phase-sequence violation.
- `err_timing` out 1: sticky flag for a wrong dwell length.
- `rotations` out CNT_W: count of completed EY→NG transitions. Saturates at all-ones.

## Operation
- **Input stage:** all 12 lamp bits are registered every clock (`s_*`). All decode uses the registered copy only.
- **Legal pattern:**
  - Every bus is one-hot.
  - Exactly one direction is non-red.
  - That direction shows green or yellow, and the others show red.
  - The active direction and colour map to the phase code listed above.
  - All-red, multi-lamp, zero-lamp and two-active-direction patterns are illegal.
- **State IDLE** (entered on reset):
  - `phase_valid`=0.
  - On the first legal sampled pattern: load `phase`, set `dur`=1, go to TRACK.
  - No order or timing check is made on lock-in, because the first dwell may be partial.
  - An illegal pattern in IDLE sets `err_pattern` and the block stays in IDLE.
- **State TRACK:**
  - Same legal phase as the previous sample: `dur` increments, saturating at 2^DUR_W-1.
  - Different legal phase:
    - The completed phase is checked: `dur` must equal GREEN_CYCLES for an even phase and YELLOW_CYCLES for an odd phase. A mismatch sets `err_timing`.
    - The new phase must equal (old+1) mod 8. Otherwise `err_order` is set.
    - A legal transition from 7 to 0 increments `rotations`.
    - `phase` is loaded with the new value and `dur` is set to 1, even when an error is flagged; tracking continues from the new phase.
  - Illegal pattern: set `err_pattern`, drop `phase_valid`, go to IDLE (resync). The partial dwell is discarded with no timing check.
- **Error flags:** each flag holds until `clear` or `rst`. If `clear` and a new error occur in the same cycle, the error wins and the flag stays 1.
- **`rotations`:** cleared only by `rst`, not by `clear`.

## Timing
- **Reset values** (asynchronous, while `rst`=1):
  - `phase`=0, `phase_valid`=0, all error flags=0, `rotations`=0.
  - State is IDLE, `dur`=0, and all input registers are 0. All zeros reads as an illegal pattern but is not flagged while `rst` is held.
- **Latency:** a lamp pattern present before edge k is registered at edge k. Its effect appears on `phase`, `phase_valid`, the error flags and `rotations` after edge k+1, so latency is 2 clocks.
- **`clear` latency:** `clear` high before edge k gives flags at 0 after edge k.
- **Dwell counting:** `dur` counts sampled clocks, so a lamp held for N clocks measures N. Input registering delays both ends of a phase equally and does not bias the count.
- **Mid-operation reset:** every output returns to its reset value immediately. After release the block relocks on the first legal pattern with no `err_order` or `err_timing`.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` for 2 clocks with random lamps.
  - Required: all outputs 0, and they stay 0 while `rst` is held.
  - After release, drive NG (north 001, others 100): `phase_valid`=1 and `phase`=0 two clocks later.
- **Nominal rotation:**
  - Stimulus: stub controller with GREEN=20 and YELLOW=5 runs 205 clocks starting in NG.
  - Required: no error flags; `rotations`=2 after the second EY→NG; `phase` steps 0..7.
- **Short dwell:**
  - Stimulus: hold WG for 19 clocks, then go to WY.
  - Required: `err_timing`=1 two clocks after the change; `err_order`=0; `phase`=3.
  - `clear` pulse: flag returns to 0. `clear` in the same cycle as a second violation: flag stays 1.
- **Order skip:**
  - Stimulus: NY(5 clocks) → SG.
  - Required: `err_order`=1, `err_timing`=0, `phase`=4, tracking continues.
- **Conflict:**
  - Stimulus: north=001 and east=001 for one clock.
  - Required: `err_pattern`=1, `phase_valid`=0.
  - On the next legal pattern the block relocks without `err_order`.
  - Also drive all-red for 1 clock: `err_pattern`=1.
- **Mid-operation reset:**
  - Stimulus: assert `rst` during SY.
  - Required: outputs 0 within the same cycle.
  - After release with the controller restarting at NG: no errors, and `rotations` restarts from 0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four lamp buses of traffic_light_controller: decodes the
// phase, tracks rotation order and dwell lengths, and raises sticky error flags.
module traffic_light_monitor #(
   parameter int GREEN_CYCLES  = 20,
   parameter int YELLOW_CYCLES = 5,
   parameter int DUR_W         = 8,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       north_light,
   input  logic [2:0]       west_light,
   input  logic [2:0]       south_light,
   input  logic [2:0]       east_light,
   input  logic             clear,
   output logic [2:0]       phase,
   output logic             phase_valid,
   output logic             err_pattern,
   output logic             err_order,
   output logic             err_timing,
   output logic [CNT_W-1:0] rotations
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam logic [DUR_W-1:0] DUR_MAX    = '1;
   localparam logic [DUR_W-1:0] GREEN_DUR  = DUR_W'(GREEN_CYCLES);
   localparam logic [DUR_W-1:0] YELLOW_DUR = DUR_W'(YELLOW_CYCLES);

   logic [2:0]       s_north, s_west, s_south, s_east;
   logic             s_loaded;
   logic [0:0]       state, state_nxt;
   logic [DUR_W-1:0] dur, dur_nxt;
   logic [2:0]       phase_nxt;
   logic             phase_valid_nxt;
   logic             pat_legal;
   logic [2:0]       dec_phase;
   logic [2:0]       active_cnt;
   logic [2:0]       bus [4];
   logic             new_pattern, new_order, new_timing, rot_inc;

   // s_loaded marks that the input registers hold a real sample, so the all-zero
   // reset contents are never decoded as an illegal pattern after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_north  <= '0;
         s_west   <= '0;
         s_south  <= '0;
         s_east   <= '0;
         s_loaded <= 1'b0;
      end else begin
         s_north  <= north_light;
         s_west   <= west_light;
         s_south  <= south_light;
         s_east   <= east_light;
         s_loaded <= 1'b1;
      end
   end

   // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      bus[0]     = s_north;
      bus[1]     = s_west;
      bus[2]     = s_south;
      bus[3]     = s_east;
      pat_legal  = 1'b1;
      active_cnt = '0;
      dec_phase  = '0;
      for (int i = 0; i < 4; i++) begin
         case (bus[i])
            LAMP_RED: ;
            LAMP_GREEN: begin
               active_cnt = active_cnt + 3'd1;
               dec_phase  = {2'(i), 1'b0};
            end
            LAMP_YELLOW: begin
               active_cnt = active_cnt + 3'd1;
               dec_phase  = {2'(i), 1'b1};
            end
            default: pat_legal = 1'b0;
         endcase
      end
      if (active_cnt != 3'd1) pat_legal = 1'b0;
   end

   always_comb begin
      state_nxt       = state;
      phase_nxt       = phase;
      phase_valid_nxt = phase_valid;
      dur_nxt         = dur;
      new_pattern     = 1'b0;
      new_order       = 1'b0;
      new_timing      = 1'b0;
      rot_inc         = 1'b0;
      if (s_loaded) begin
         if (!pat_legal) begin
            // Resync: the partial dwell is dropped without a timing check.
            new_pattern     = 1'b1;
            state_nxt       = ST_IDLE;
            phase_valid_nxt = 1'b0;
            dur_nxt         = '0;
         end else if (state == ST_IDLE) begin
            state_nxt       = ST_TRACK;
            phase_nxt       = dec_phase;
            phase_valid_nxt = 1'b1;
            dur_nxt         = DUR_W'(1);
         end else if (dec_phase == phase) begin
            dur_nxt = (dur == DUR_MAX) ? dur : dur + DUR_W'(1);
         end else begin
            new_timing = (dur != (phase[0] ? YELLOW_DUR : GREEN_DUR));
            new_order  = (dec_phase != phase + 3'd1);
            rot_inc    = (phase == 3'd7) && (dec_phase == 3'd0);
            phase_nxt  = dec_phase;
            dur_nxt    = DUR_W'(1);
         end
      end
   end

   // A new error outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         dur         <= '0;
         phase       <= '0;
         phase_valid <= 1'b0;
         err_pattern <= 1'b0;
         err_order   <= 1'b0;
         err_timing  <= 1'b0;
         rotations   <= '0;
      end else begin
         state       <= state_nxt;
         dur         <= dur_nxt;
         phase       <= phase_nxt;
         phase_valid <= phase_valid_nxt;
         err_pattern <= (err_pattern & ~clear) | new_pattern;
         err_order   <= (err_order & ~clear) | new_order;
         err_timing  <= (err_timing & ~clear) | new_timing;
         if (rot_inc && (rotations != '1)) rotations <= rotations + CNT_W'(1);
      end
   end

endmodule
